// File: rtl/pipe_reg.sv
// Elastic pipeline register: valid/ready handshake with a two-entry skid buffer and flush.
// Define PIPE_REG_PERF_EN to build the saturating stall counter; otherwise stall_cnt reads zero.
module pipe_reg #(
   parameter int             N         = 32,
   parameter logic [N-1:0]   RESET_VAL = {N{1'b0}},
   parameter int             CW        = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          flush,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [N-1:0]  in,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [N-1:0]  out,
   output logic [1:0]    count,
   output logic [CW-1:0] stall_cnt
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t       state_reg, state_next;
   logic [N-1:0] main_reg, main_next;
   logic [N-1:0] skid_reg, skid_next;
   logic         accept;
   logic         emit;

   // Handshake outputs decode from state only, so ready never depends combinationally on out_ready.
   assign in_ready  = (state_reg != FULL);
   assign out_valid = (state_reg != EMPTY);
   assign out       = main_reg;
   assign count     = state_reg;

   assign accept = in_valid & in_ready;
   assign emit   = out_valid & out_ready;

   always_comb begin
      state_next = state_reg;
      main_next  = main_reg;
      skid_next  = skid_reg;
      if (flush) begin
         // Data registers are left alone so a dropped input never reaches out.
         state_next = EMPTY;
      end else begin
         case (state_reg)
            EMPTY: begin
               if (accept) begin
                  state_next = ONE;
                  main_next  = in;
               end
            end
            ONE: begin
               if (accept && emit) begin
                  main_next = in;
               end else if (accept) begin
                  state_next = FULL;
                  skid_next  = in;
               end else if (emit) begin
                  state_next = EMPTY;
               end
            end
            FULL: begin
               if (emit) begin
                  state_next = ONE;
                  main_next  = skid_reg;
               end
            end
            default: state_next = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg <= EMPTY;
         main_reg  <= RESET_VAL;
         skid_reg  <= RESET_VAL;
      end else begin
         state_reg <= state_next;
         main_reg  <= main_next;
         skid_reg  <= skid_next;
      end
   end

`ifdef PIPE_REG_PERF_EN
   logic [CW-1:0] stall_reg;

   // Saturates at all-ones; flush deliberately leaves it alone.
   always_ff @(posedge clk) begin
      if (!reset) begin
         stall_reg <= {CW{1'b0}};
      end else if (out_valid && !out_ready && (stall_reg != {CW{1'b1}})) begin
         stall_reg <= stall_reg + CW'(1'b1);
      end
   end

   assign stall_cnt = stall_reg;
`else
   assign stall_cnt = {CW{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_reg.sv
// Directed vector bench for pipe_reg: reset, streaming, skid backpressure, flush,
// mid-operation reset and the stall counter (expectations depend on PIPE_REG_PERF_EN).
module tb_pipe_reg;

   localparam int N  = 32;
   localparam int CW = 2;

   logic          clk;
   logic          reset;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [N-1:0]  in;
   logic          out_valid;
   logic          out_ready;
   logic [N-1:0]  out;
   logic [1:0]    count;
   logic [CW-1:0] stall_cnt;

   int n_cmp = 0;
   int n_err = 0;

   pipe_reg #(.N(N), .RESET_VAL({N{1'b0}}), .CW(CW)) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in        (in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .count     (count),
      .stall_cnt (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // out_mode: 0 = out must equal exp_out, 1 = out must differ from exp_out
   typedef struct {
      logic        rst_n;
      logic        fl;
      logic        iv;
      logic        ordy;
      logic [31:0] din;
      logic [1:0]  exp_cnt;
      logic        exp_vld;
      logic        exp_rdy;
      logic [31:0] exp_out;
      int          out_mode;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic rst_n, input logic fl, input logic iv, input logic ordy,
                      input logic [31:0] din, input logic [1:0] ec, input logic ev,
                      input logic er, input logic [31:0] eo, input int om);
      vec_t v;
      v.rst_n = rst_n; v.fl = fl; v.iv = iv; v.ordy = ordy; v.din = din;
      v.exp_cnt = ec; v.exp_vld = ev; v.exp_rdy = er; v.exp_out = eo; v.out_mode = om;
      vq.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_ne(input string name, input logic [31:0] act, input logic [31:0] bad);
      n_cmp++;
      if (act === bad) begin
         n_err++;
         $display("FAIL %s: got %h expected anything but %h", name, act, bad);
      end
   endtask

   task automatic drive(input logic rst_n, input logic fl, input logic iv,
                        input logic ordy, input logic [31:0] din);
      reset = rst_n; flush = fl; in_valid = iv; out_ready = ordy; in = din;
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [CW-1:0] exp_stall(input int v);
`ifdef PIPE_REG_PERF_EN
      return CW'(v);
`else
      return {CW{1'b0}};
`endif
   endfunction

   initial begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

      // reset held two cycles with input presented
      add(0,0,1,0,32'hDEAD_BEEF, 0,0,1,32'h0, 0);
      add(0,0,1,0,32'hDEAD_BEEF, 0,0,1,32'h0, 0);
      // streaming at one per cycle
      add(1,0,1,1,32'd1, 1,1,1,32'd1, 0);
      add(1,0,1,1,32'd2, 1,1,1,32'd2, 0);
      add(1,0,1,1,32'd3, 1,1,1,32'd3, 0);
      add(1,0,1,1,32'd4, 1,1,1,32'd4, 0);
      add(1,0,0,1,32'd0, 0,0,1,32'd4, 0);
      // backpressure fills the skid, then drains in order
      add(1,0,1,0,32'hA5, 1,1,1,32'hA5, 0);
      add(1,0,1,0,32'h5A, 2,1,0,32'hA5, 0);
      add(1,0,1,0,32'h33, 2,1,0,32'hA5, 0);
      add(1,0,0,1,32'h0,  1,1,1,32'h5A, 0);
      add(1,0,0,1,32'h0,  0,0,1,32'h5A, 0);
      // flush from FULL with input offered
      add(1,0,1,0,32'h11, 1,1,1,32'h11, 0);
      add(1,0,1,0,32'h22, 2,1,0,32'h11, 0);
      add(1,1,1,0,32'h77, 0,0,1,32'h77, 1);
      // flush from ONE with accept and emit in the same cycle
      add(1,0,1,1,32'h44, 1,1,1,32'h44, 0);
      add(1,1,1,1,32'h77, 0,0,1,32'h77, 1);
      add(1,0,0,0,32'h0,  0,0,1,32'h77, 1);
      // reset in the middle of a full buffer
      add(1,0,1,0,32'h55, 1,1,1,32'h55, 0);
      add(1,0,1,0,32'h66, 2,1,0,32'h55, 0);
      add(0,0,1,1,32'h88, 0,0,1,32'h0,  0);
      add(1,0,1,1,32'd9,  1,1,1,32'd9,  0);
      add(1,0,0,0,32'h0,  1,1,1,32'd9,  0);

      for (int i = 0; i < vq.size(); i++) begin
         drive(vq[i].rst_n, vq[i].fl, vq[i].iv, vq[i].ordy, vq[i].din);
         step();
         $display("vec %0d: rst=%b fl=%b iv=%b ordy=%b in=%h -> cnt=%0d vld=%b rdy=%b out=%h",
                  i, vq[i].rst_n, vq[i].fl, vq[i].iv, vq[i].ordy, vq[i].din,
                  count, out_valid, in_ready, out);
         check($sformatf("vec%0d count", i), 32'(count), 32'(vq[i].exp_cnt));
         check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vq[i].exp_vld));
         check($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(vq[i].exp_rdy));
         if (vq[i].out_mode == 0)
            check($sformatf("vec%0d out", i), out, vq[i].exp_out);
         else
            check_ne($sformatf("vec%0d out", i), out, vq[i].exp_out);
      end

      // stall counter: reset, load one entry, then hold out_ready low
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      step();
      check("stall after reset", 32'(stall_cnt), 32'(exp_stall(0)));
      drive(1'b1, 1'b0, 1'b1, 1'b0, 32'hC3);
      step();
      $display("perf load: out=%h stall_cnt=%0d", out, stall_cnt);
      check("stall at load", 32'(stall_cnt), 32'(exp_stall(0)));
      check("perf load out", out, 32'hC3);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      for (int k = 1; k <= 5; k++) begin
         step();
         $display("perf cycle %0d: stall_cnt=%0d", k, stall_cnt);
         check($sformatf("stall cycle %0d", k), 32'(stall_cnt), 32'(exp_stall(k > 3 ? 3 : k)));
      end
      // flush does not clear the counter; stall stops once nothing is valid
      drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      step();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      step();
      $display("perf after flush: stall_cnt=%0d out_valid=%b", stall_cnt, out_valid);
      check("stall after flush", 32'(stall_cnt), 32'(exp_stall(3)));
      check("valid after flush", 32'(out_valid), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
